ktms_mmio_init: RTL

KTMS_MMIO_INIT -- requirements
Module: ktms_mmio_init

---
 rtl/ktms_mmio_init.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ktms_mmio_init.sv
// ktms_mmio_init: accepts one MMIO request at a time, formats it onto the MMIO
// command bus for a single cycle and, for reads, waits for the responder's data
// before presenting it on a ready/valid response port.
// Optional feature macro: KTMS_MMIO_TIMEOUT_EN adds a read-timeout counter that
// returns all-ones data with o_rsp_err set when the responder stays silent.
module ktms_mmio_init #(
  parameter int mmiobus_width = 94,
  parameter int timeout_width = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_req_v,
  output logic                     o_req_r,
  input  logic                     i_req_rnw,
  input  logic                     i_req_cfg,
  input  logic                     i_req_dw,
  input  logic [23:0]              i_req_addr,
  input  logic [63:0]              i_req_d,
  output logic [mmiobus_width-1:0] o_mmiobus,
  input  logic                     i_mmio_rd_v,
  input  logic [63:0]              i_mmio_rd_d,
  output logic                     o_rsp_v,
  input  logic                     i_rsp_r,
  output logic [63:0]              o_rsp_d,
  output logic                     o_rsp_err,
  input  logic [timeout_width-1:0] i_timeout,
  output logic                     o_busy,
  output logic                     o_stray
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RSP     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        r_rnw;
  logic        r_cfg;
  logic        r_dw;
  logic [23:0] r_addr;
  logic [63:0] r_data;
  logic [63:0] r_rsp_d;
  logic        r_stray;

  logic        w_accept;
  logic        w_timeout_hit;
  logic [63:0] w_data_field;
  logic        w_addr_par;
  logic        w_data_par;
  logic [93:0] w_cmd;

  assign w_accept = i_req_v && (r_state == IDLE);

`ifdef KTMS_MMIO_TIMEOUT_EN
  localparam logic [timeout_width-1:0] CntOne = timeout_width'(1);

  logic [timeout_width-1:0] r_cnt;
  logic                     r_rsp_err;

  assign w_timeout_hit = (r_cnt == '0);

  // Timeout counter: loaded as a read leaves ISSUE, counts down while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ISSUE && r_rnw) begin
      r_cnt <= i_timeout;
    end else if (r_state == WAIT_RD && !i_mmio_rd_v && r_cnt != '0) begin
      r_cnt <= r_cnt - CntOne;
    end
  end

  // Error flag records whether the held response came from a timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_err <= 1'b0;
    end else if (r_state == WAIT_RD) begin
      if (i_mmio_rd_v) begin
        r_rsp_err <= 1'b0;
      end else if (w_timeout_hit) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign o_rsp_err = r_rsp_err && !reset;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^i_timeout;
  assign w_timeout_hit    = 1'b0;
  assign o_rsp_err        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; read data always wins over a same-cycle timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_req_v) w_next = ISSUE;
      ISSUE:   w_next = r_rnw ? WAIT_RD : IDLE;
      WAIT_RD: if (i_mmio_rd_v || w_timeout_hit) w_next = RSP;
      RSP:     if (i_rsp_r) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Capture every request field on acceptance so the inputs may change freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rnw  <= 1'b0;
      r_cfg  <= 1'b0;
      r_dw   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_rnw  <= i_req_rnw;
      r_cfg  <= i_req_cfg;
      r_dw   <= i_req_dw;
      r_addr <= i_req_addr;
      r_data <= i_req_d;
    end
  end

  // Response data: responder data, or all-ones when the wait timed out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_d <= '0;
    end else if (r_state == WAIT_RD) begin
      if (i_mmio_rd_v) begin
        r_rsp_d <= i_mmio_rd_d;
      end else if (w_timeout_hit) begin
        r_rsp_d <= '1;
      end
    end
  end

  // Sticky flag for read data that shows up when no read is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stray <= 1'b0;
    end else if (i_mmio_rd_v && r_state != WAIT_RD) begin
      r_stray <= 1'b1;
    end
  end

  assign w_data_field = r_rnw ? 64'd0 : r_data;
  assign w_addr_par   = ~^r_addr;
  assign w_data_par   = ~^w_data_field;
  assign w_cmd        = {1'b1, r_cfg, r_rnw, r_dw, r_addr, w_addr_par,
                         w_data_field, w_data_par};

  assign o_mmiobus = (r_state == ISSUE && !reset) ? mmiobus_width'(w_cmd) : '0;
  assign o_req_r   = (r_state == IDLE) && !reset;
  assign o_busy    = (r_state != IDLE) && !reset;
  assign o_rsp_v   = (r_state == RSP) && !reset;
  assign o_rsp_d   = reset ? 64'd0 : r_rsp_d;
  assign o_stray   = r_stray && !reset;

endmodule
